// File: rtl/out_port_serializer.sv
// Buffers CPU output-port words in a small FIFO and streams each word to an
// 8-bit valid/ready sink, high byte first.
module out_port_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  out_ld_i,
  input  logic [DATA_WIDTH-1:0] out_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  state_e                state_q, state_d;

  logic push_ok;
  logic pop;
  logic fifo_empty;
  logic fifo_full;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign push_ok    = out_ld_i && !fifo_full;

  assign count_o    = count_q;
  assign empty_o    = fifo_empty;
  assign full_o     = fifo_full;
  assign overflow_o = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
    if (out_ld_i && fifo_full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= out_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      word_q     <= '0;
      state_q    <= S_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      word_q     <= word_d;
      state_q    <= state_d;
    end
  end

  // The low-byte state pops the next word directly so a full stream has no idle bubble.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    byte_o       = '0;
    byte_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_HI;
        end
      end
      S_HI: begin
        byte_o       = word_q[DATA_WIDTH-1 -: 8];
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          state_d = S_LO;
        end
      end
      S_LO: begin
        byte_o       = word_q[7:0];
        byte_valid_o = 1'b1;
        if (byte_ready_i) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_HI;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    word_d = pop ? mem_q[rd_ptr_q] : word_q;
  end

endmodule

// File: tb/tb_out_port_serializer.sv
// Directed bench for out_port_serializer: reset, latency, streaming,
// back-pressure, overflow, pointer wrap and asynchronous reset mid-word.
module tb_out_port_serializer;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        out_ld_i;
  logic [15:0] out_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic [3:0]  count_o;
  logic        empty_o;
  logic        full_o;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;

  out_port_serializer #(
    .DATA_WIDTH(16),
    .DEPTH_LOG2(3)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .out_ld_i     (out_ld_i),
    .out_i        (out_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_ni     = 1'b0;
    out_ld_i     = 1'b0;
    byte_ready_i = 1'b0;
    step();
    step();
    reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    reset_ni     = 1'b0;
    out_ld_i     = 1'b0;
    out_i        = '0;
    byte_ready_i = 1'b0;
    #3;
    checks++;
    if ({byte_valid_o, byte_o, count_o, empty_o, full_o, overflow_o} !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b byte=%h count=%0d empty=%b full=%b ovf=%b, required 0 00 0 1 0 0",
               byte_valid_o, byte_o, count_o, empty_o, full_o, overflow_o);
    end
    step();
    step();
    reset_ni = 1'b1;
  endtask

  task automatic test_single();
    byte_ready_i = 1'b1;
    out_ld_i     = 1'b1;
    out_i        = 16'hA55A;
    step();
    out_ld_i = 1'b0;
    checks++;
    if (count_o !== 4'd1 || byte_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: count=%0d valid=%b, required 1 0", count_o, byte_valid_o);
    end
    step();
    checks++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'hA5 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL single_hi: valid=%b byte=%h count=%0d, required 1 a5 0", byte_valid_o, byte_o, count_o);
    end
    step();
    checks++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h5A) begin
      errors++;
      $display("FAIL single_lo: valid=%b byte=%h, required 1 5a", byte_valid_o, byte_o);
    end
    step();
    checks++;
    if (byte_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL single_done: valid=%b empty=%b, required 0 1", byte_valid_o, empty_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    byte_ready_i = 1'b1;
    out_ld_i     = 1'b1;
    out_i        = 16'h1234;
    step();
    out_i = 16'h5678;
    step();
    out_ld_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (byte_valid_o !== 1'b1 || byte_o !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: valid=%b byte=%h, required 1 %h", i, byte_valid_o, byte_o, exp_b[i]);
      end
      step();
    end
    checks++;
    if (byte_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: valid=%b empty=%b, required 0 1", byte_valid_o, empty_o);
    end
  endtask

  task automatic test_backpressure();
    byte_ready_i = 1'b0;
    out_ld_i     = 1'b1;
    out_i        = 16'hA55A;
    step();
    out_ld_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (byte_valid_o !== 1'b1 || byte_o !== 8'hA5) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b byte=%h, required 1 a5", i, byte_valid_o, byte_o);
      end
      if (i < 4) step();
    end
    byte_ready_i = 1'b1;
    step();
    checks++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h5A) begin
      errors++;
      $display("FAIL bp_release: valid=%b byte=%h, required 1 5a", byte_valid_o, byte_o);
    end
    step();
    checks++;
    if (byte_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: valid=%b, required 0", byte_valid_o);
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] rx [$];
    logic [7:0] exp_byte;
    byte_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (overflow_o !== 1'b0) begin
        errors++;
        $display("FAIL ovf_early%0d: overflow=%b, required 0", i, overflow_o);
      end
      out_ld_i = 1'b1;
      out_i    = 16'(i);
      step();
    end
    out_ld_i = 1'b0;
    checks++;
    if (count_o !== 4'd8 || full_o !== 1'b1 || overflow_o !== 1'b1 || empty_o !== 1'b0) begin
      errors++;
      $display("FAIL full_state: count=%0d full=%b ovf=%b empty=%b, required 8 1 1 0",
               count_o, full_o, overflow_o, empty_o);
    end
    checks++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h00) begin
      errors++;
      $display("FAIL full_head: valid=%b byte=%h, required 1 00", byte_valid_o, byte_o);
    end
    byte_ready_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (byte_valid_o === 1'b1) rx.push_back(byte_o);
      step();
    end
    checks++;
    if (rx.size() != 18) begin
      errors++;
      $display("FAIL drain_count: bytes=%0d, required 18", rx.size());
    end
    for (int i = 0; i < 18 && i < rx.size(); i++) begin
      exp_byte = (i % 2 == 0) ? 8'h00 : 8'(i / 2);
      checks++;
      if (rx[i] !== exp_byte) begin
        errors++;
        $display("FAIL drain_byte%0d: got %h, required %h", i, rx[i], exp_byte);
      end
    end
    checks++;
    if (overflow_o !== 1'b1 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: ovf=%b empty=%b full=%b, required 1 1 0", overflow_o, empty_o, full_o);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  rx [$];
    logic [15:0] w;
    logic [7:0]  exp_byte;
    int          max_count = 0;
    logic        ovf_seen  = 1'b0;
    do_reset();
    byte_ready_i = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c < 40 && c % 2 == 0) begin
        out_ld_i = 1'b1;
        out_i    = 16'h1000 + 16'(3 * (c / 2)) + 16'h0101 * 16'(c / 2);
      end else begin
        out_ld_i = 1'b0;
      end
      if (byte_valid_o === 1'b1) rx.push_back(byte_o);
      step();
      if (int'(count_o) > max_count) max_count = int'(count_o);
      if (overflow_o !== 1'b0) ovf_seen = 1'b1;
    end
    checks++;
    if (max_count > 1) begin
      errors++;
      $display("FAIL wrap_maxcount: max count=%0d, required <=1", max_count);
    end
    checks++;
    if (ovf_seen !== 1'b0) begin
      errors++;
      $display("FAIL wrap_overflow: overflow seen=%b, required 0", ovf_seen);
    end
    checks++;
    if (rx.size() != 40) begin
      errors++;
      $display("FAIL wrap_count: bytes=%0d, required 40", rx.size());
    end
    for (int i = 0; i < 40 && i < rx.size(); i++) begin
      w = 16'h1000 + 16'(3 * (i / 2)) + 16'h0101 * 16'(i / 2);
      exp_byte = (i % 2 == 0) ? w[15:8] : w[7:0];
      checks++;
      if (rx[i] !== exp_byte) begin
        errors++;
        $display("FAIL wrap_byte%0d: got %h, required %h", i, rx[i], exp_byte);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic stray = 1'b0;
    do_reset();
    byte_ready_i = 1'b0;
    out_ld_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_i = 16'hBE00 + 16'(i);
      step();
    end
    out_ld_i = 1'b0;
    step();
    byte_ready_i = 1'b1;
    step();
    checks++;
    if (byte_valid_o !== 1'b1 || byte_o !== 8'h00 || count_o !== 4'd2) begin
      errors++;
      $display("FAIL mid_in_lo: valid=%b byte=%h count=%0d, required 1 00 2", byte_valid_o, byte_o, count_o);
    end
    #2;
    reset_ni = 1'b0;
    #1;
    checks++;
    if ({byte_valid_o, byte_o, count_o, empty_o, full_o, overflow_o} !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_async: valid=%b byte=%h count=%0d empty=%b full=%b ovf=%b, required 0 00 0 1 0 0",
               byte_valid_o, byte_o, count_o, empty_o, full_o, overflow_o);
    end
    step();
    step();
    reset_ni = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (byte_valid_o !== 1'b0 || count_o !== 4'd0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_release: stray activity=%b, required 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_overflow();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
